// File: rtl/goe_pkg.sv
// Shared definitions for the GOE egress path: word tags, field positions,
// descriptor geometry and FSM state encodings.
package goe_pkg;
  localparam int WORD_W = 134;
  localparam int TAG_HI = 133;
  localparam int TAG_LO = 132;
  localparam int INV_HI = 131;
  localparam int INV_LO = 128;
  localparam int PAY_HI = 127;

  localparam logic [1:0] TAG_HEAD = 2'b01;
  localparam logic [1:0] TAG_BODY = 2'b11;
  localparam logic [1:0] TAG_TAIL = 2'b10;

  // descriptor = {start address, word count}
  localparam int LEN_W = 8;
  function automatic int desc_w(input int addr_w);
    return addr_w + LEN_W;
  endfunction

  typedef enum logic [1:0] {W_IDLE, W_STORE, W_DROP, W_WAIT_VALID} wr_state_e;
  typedef enum logic {R_IDLE, R_SEND} rd_state_e;
endpackage

// File: rtl/goe_tx_buf_if.sv
// Packet-in / packet-out handshake bundle between switch core, buffer and MAC.
interface goe_tx_buf_if;
  import goe_pkg::*;
  logic [WORD_W-1:0] in_data;
  logic              in_data_wr;
  logic              in_valid;
  logic              in_valid_wr;
  logic              out_ready;
  logic [WORD_W-1:0] out_data;
  logic              out_data_wr;
  logic              out_valid;
  logic              out_valid_wr;

  modport master (output in_data, in_data_wr, in_valid, in_valid_wr, out_ready,
                  input  out_data, out_data_wr, out_valid, out_valid_wr);
  modport slave  (input  in_data, in_data_wr, in_valid, in_valid_wr, out_ready,
                  output out_data, out_data_wr, out_valid, out_valid_wr);
endinterface

// File: rtl/goe_sdp_ram.sv
// Simple dual-port RAM, one write port, one read port with 1-cycle registered read.
module goe_sdp_ram #(
  parameter int AW = 8,
  parameter int DW = 134
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [2**AW];

  // same-address read/write returns the old contents
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/goe_tx_buf.sv
// Store-and-forward egress buffer for one GOE port: keeps only complete good
// packets and releases each one as a gapless burst once the MAC has room.
module goe_tx_buf
  import goe_pkg::*;
#(
  parameter int ADDR_W        = 8,
  parameter int MAX_PKT_WORDS = 96,
  parameter int PKT_Q_LOG2    = 4
) (
  input  logic              clk,
  input  logic              rst,
  goe_tx_buf_if.slave       bus,
  output logic [63:0]       pkt_in_cnt,
  output logic [63:0]       pkt_drop_cnt,
  output logic [63:0]       pkt_out_cnt,
  output logic [ADDR_W:0]   buf_used
);
  localparam int DW_D = desc_w(ADDR_W);
  localparam logic [ADDR_W:0] DEPTH_P = (ADDR_W+1)'(1 << ADDR_W);

  // write side
  wr_state_e         ws, ws_n;
  logic [ADDR_W:0]   wr_ptr, wr_ptr_n, wr_start, wr_start_n, rd_ptr;
  logic [LEN_W-1:0]  wcnt, wcnt_n, push_len;
  logic              discard, discard_n;
  logic              d_we, push, in_inc, drop_inc;
  logic [ADDR_W-1:0] d_waddr;
  logic [1:0]        tag;
  logic              is_head, is_tail, holding, hd_ok;
  logic [ADDR_W:0]   base, free_b;

  // descriptor queue
  logic [PKT_Q_LOG2:0]   dq_wp, dq_rp, dq_cnt;
  logic [PKT_Q_LOG2-1:0] dq_raddr;
  logic [DW_D-1:0]       dq_wdata, dq_rdata, fwd_q, head;
  logic                  fwd_vld, dq_full, dq_empty;

  // read side
  rd_state_e         rs, rs_n;
  logic [ADDR_W-1:0] rd_addr, rd_addr_n, r_addr, hd_start;
  logic [LEN_W-1:0]  rem, rem_n, hd_len;
  logic              pop, issue, issue_last, vld_q, last_q;
  logic [WORD_W-1:0] d_rdata;

  assign tag     = bus.in_data[TAG_HI:TAG_LO];
  assign is_head = bus.in_data_wr && (tag == TAG_HEAD);
  assign is_tail = bus.in_data_wr && (tag == TAG_TAIL);
  // while a packet holds words, a new head is admitted as if it had been rolled back
  assign holding = (ws == W_STORE) || (ws == W_WAIT_VALID && !discard);
  assign base    = holding ? wr_start : wr_ptr;
  assign free_b  = DEPTH_P - (base - rd_ptr);
  assign hd_ok   = (free_b >= (ADDR_W+1)'(MAX_PKT_WORDS)) && !dq_full;

  always_comb begin
    ws_n = ws; wr_ptr_n = wr_ptr; wr_start_n = wr_start; wcnt_n = wcnt;
    discard_n = discard; d_we = 1'b0; d_waddr = wr_ptr[ADDR_W-1:0];
    push = 1'b0; push_len = wcnt; in_inc = 1'b0; drop_inc = 1'b0;
    if (is_head) begin
      drop_inc  = (ws != W_IDLE);
      wr_ptr_n  = base;
      discard_n = 1'b0;
      if (hd_ok) begin
        d_we = 1'b1; d_waddr = base[ADDR_W-1:0];
        wr_ptr_n = base + 1'b1; wr_start_n = base; wcnt_n = LEN_W'(1);
        ws_n = W_STORE;
      end else begin
        discard_n = 1'b1; ws_n = W_DROP;
      end
    end else begin
      case (ws)
        W_STORE: if (bus.in_data_wr) begin
          if (wcnt == LEN_W'(MAX_PKT_WORDS)) begin
            // oversize: give the words back now, count the drop at packet end
            wr_ptr_n = wr_start; discard_n = 1'b1;
            if (!is_tail) ws_n = W_DROP;
            else if (bus.in_valid_wr) begin
              drop_inc = 1'b1; discard_n = 1'b0; ws_n = W_IDLE;
            end else ws_n = W_WAIT_VALID;
          end else begin
            d_we = 1'b1; wr_ptr_n = wr_ptr + 1'b1; wcnt_n = wcnt + 1'b1;
            if (is_tail) begin
              if (!bus.in_valid_wr) ws_n = W_WAIT_VALID;
              else begin
                ws_n = W_IDLE;
                if (bus.in_valid) begin
                  push = 1'b1; push_len = wcnt + 1'b1; in_inc = 1'b1;
                end else begin
                  wr_ptr_n = wr_start; drop_inc = 1'b1;
                end
              end
            end
          end
        end
        W_WAIT_VALID: if (bus.in_valid_wr) begin
          ws_n = W_IDLE; discard_n = 1'b0;
          if (!discard && bus.in_valid) begin
            push = 1'b1; in_inc = 1'b1;
          end else begin
            drop_inc = 1'b1;
            if (!discard) wr_ptr_n = wr_start;
          end
        end
        W_DROP: if (is_tail) begin
          if (bus.in_valid_wr) begin
            drop_inc = 1'b1; discard_n = 1'b0; ws_n = W_IDLE;
          end else ws_n = W_WAIT_VALID;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ws <= W_IDLE; wr_ptr <= '0; wr_start <= '0; wcnt <= '0; discard <= 1'b0;
      pkt_in_cnt <= '0; pkt_drop_cnt <= '0;
    end else begin
      ws <= ws_n; wr_ptr <= wr_ptr_n; wr_start <= wr_start_n; wcnt <= wcnt_n;
      discard <= discard_n;
      pkt_in_cnt   <= pkt_in_cnt + 64'(in_inc);
      pkt_drop_cnt <= pkt_drop_cnt + 64'(drop_inc);
    end
  end

  // Descriptor queue; the registered read always tracks the next head, and a
  // push landing on that address is forwarded so a fresh commit pops at once.
  assign dq_cnt   = dq_wp - dq_rp;
  assign dq_full  = dq_cnt[PKT_Q_LOG2];
  assign dq_empty = (dq_cnt == '0);
  assign dq_wdata = {wr_start[ADDR_W-1:0], push_len};
  assign dq_raddr = dq_rp[PKT_Q_LOG2-1:0] + PKT_Q_LOG2'(pop);
  assign head     = fwd_vld ? fwd_q : dq_rdata;
  assign hd_start = head[DW_D-1:LEN_W];
  assign hd_len   = head[LEN_W-1:0];

  goe_sdp_ram #(.AW(PKT_Q_LOG2), .DW(DW_D)) u_dq (
    .clk(clk), .we(push), .waddr(dq_wp[PKT_Q_LOG2-1:0]), .wdata(dq_wdata),
    .re(1'b1), .raddr(dq_raddr), .rdata(dq_rdata));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dq_wp <= '0; dq_rp <= '0; fwd_vld <= 1'b0; fwd_q <= '0;
    end else begin
      dq_wp   <= dq_wp + (PKT_Q_LOG2+1)'(push);
      dq_rp   <= dq_rp + (PKT_Q_LOG2+1)'(pop);
      fwd_vld <= push && (dq_wp[PKT_Q_LOG2-1:0] == dq_raddr);
      fwd_q   <= dq_wdata;
    end
  end

  always_comb begin
    rs_n = rs; rd_addr_n = rd_addr; rem_n = rem; r_addr = rd_addr;
    pop = 1'b0; issue = 1'b0; issue_last = 1'b0;
    case (rs)
      R_IDLE: if (!dq_empty && bus.out_ready) begin
        pop = 1'b1; issue = 1'b1; r_addr = hd_start;
        rd_addr_n  = hd_start + 1'b1;
        rem_n      = hd_len - 1'b1;
        issue_last = (hd_len == LEN_W'(1));
        if (!issue_last) rs_n = R_SEND;
      end
      R_SEND: begin
        issue = 1'b1; rd_addr_n = rd_addr + 1'b1; rem_n = rem - 1'b1;
        issue_last = (rem == LEN_W'(1));
        if (issue_last) rs_n = R_IDLE;
      end
      default: ;
    endcase
  end

  goe_sdp_ram #(.AW(ADDR_W), .DW(WORD_W)) u_data (
    .clk(clk), .we(d_we), .waddr(d_waddr), .wdata(bus.in_data),
    .re(issue), .raddr(r_addr), .rdata(d_rdata));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rs <= R_IDLE; rd_addr <= '0; rem <= '0; rd_ptr <= '0;
      vld_q <= 1'b0; last_q <= 1'b0; pkt_out_cnt <= '0;
    end else begin
      rs <= rs_n; rd_addr <= rd_addr_n; rem <= rem_n;
      rd_ptr      <= rd_ptr + (ADDR_W+1)'(issue);
      vld_q       <= issue;
      last_q      <= issue_last;
      pkt_out_cnt <= pkt_out_cnt + 64'(last_q);
    end
  end

  assign bus.out_data     = vld_q ? d_rdata : '0;
  assign bus.out_data_wr  = vld_q;
  assign bus.out_valid    = last_q;
  assign bus.out_valid_wr = last_q;
  assign buf_used         = wr_ptr - rd_ptr;
endmodule
